booth_r4_seq_mult: RTL and testbench
====================================

# booth_r4_seq_mult

Sequential signed radix-4 Booth multiplier for the DNN approximate-multiplication datapath. It sits directly downstream of the radix-4 triplet encoding and consumes it: each cycle it encodes one overlapping multiplier triplet, decodes the encoding into a partial product, and accumulates it. An optional approximate mode truncates low partial-product bits. It trades throughput for area in MAC-array experiments.

## Interface
- WIDTH, 8: operand width in bits; must be even and ≥ 4.
- TRUNC_BITS, 4: number of low accumulator-aligned bits zeroed per partial product when approximation is compiled in; range 0..2*WIDTH-1.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  signed multiplicand.
- b  in  WIDTH  signed multiplier (Booth-recoded).
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  signed product, exact or approximate.

## Operation
- Triplet i, for i = 0..N-1 with N = WIDTH/2, is {b[2i+1], b[2i], b[2i-1]}, where b[-1] = 0.
- Encoding of triplet t[2:0]:
  - enc[0] = ~(t2^t1)
  - enc[1] = ~(t1^t0)
  - enc[2] = t1^t0
  - neg = t2
- Decode:
  - one = enc[2]
  - two = enc[1] & ~enc[0]
  - zero = enc[1] & enc[0]
- Partial product pp_i:
  - mag = one ? a : two ? 2a : 0, sign-extended to WIDTH+2 bits.
  - pp_i = neg ? -mag : mag. The negation is exact two's complement, so triplet 111 yields 0.
- Aligned term = sign-extend(pp_i) << 2i, in 2*WIDTH bits. The accumulator adds the aligned term modulo 2^(2*WIDTH). The exact result never overflows, including a = b = -2^(WIDTH-1).
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a and b, clear the accumulator, set i=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle add the aligned term for triplet i and increment i. After adding i=N-1, go to DONE.
  - DONE: out_valid=1 and product = accumulator. When out_ready=1, go to IDLE.
- product holds its value while out_valid=1 and out_ready=0.
- a, b and in_valid are ignored outside IDLE.
- There is no same-cycle output-accept/input-accept overlap: IDLE always follows DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, accumulator=0, i=0.
- Reset in BUSY or DONE aborts the operation. The result is discarded and is never presented.

## Timing
- Input handshake completes on the edge where in_valid & in_ready = 1 (edge E0).
- Partial products are added on edges E1..EN.
- out_valid is high from the cycle after EN, i.e. N edges after E0.
- Output handshake completes on the edge where out_valid & out_ready = 1. in_ready is high in the next cycle.
- Minimum initiation interval: N+2 cycles (N+2 = 6 for WIDTH=8).
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- BOOTH_APPROX_TRUNC_EN defined: bits [TRUNC_BITS-1:0] of each aligned term are forced to 0 before accumulation. For negative terms this rounds toward -inf. The product is approximate and is always ≤ the exact value's magnitude envelope per term.
- Undefined: no truncation, product is exact, and TRUNC_BITS is ignored.
- Latency and handshake are identical in both builds.

## Structure
- Shared package booth_r4_pkg holds:
  - typedef enc_t = struct {logic [2:0] encout; logic neg;}.
  - Function booth_r4_enc(triplet) returning enc_t per the equations above.
  - FSM state enum {S_IDLE, S_BUSY, S_DONE}.
- Sub-module booth_pp_gen (combinational): inputs a and enc_t, output WIDTH+2-bit signed pp_i. It contains the decode and the negation.
- Top-level holds the FSM, the triplet index counter, the operand registers, the accumulator and the truncation mask.

## Test plan
- Exact build, WIDTH=8: a=3, b=5 → product=15, out_valid exactly 4 edges after accept.
- Exact build: a=-128, b=-128 → product=16384; a=-128, b=127 → -16256; a=7, b=-1 (all triplets 111/110 cases) → -7.
- Backpressure: hold out_ready=0 for 10 cycles with a=-5, b=9 → product stays -45 and in_ready stays 0; release → in_ready=1 the next cycle.
- Reset mid-BUSY (assert rst on E2): out_valid never rises, product=0, in_ready=1. A following a=2, b=2 → 4.
- BOOTH_APPROX_TRUNC_EN, TRUNC_BITS=2: a=3, b=5 → product=12 (pp0=3 truncated to 0); a=-3, b=1 → -4.
- Random exhaustive WIDTH=4, exact build: all 256 operand pairs match a*b, with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/booth_r4_pkg.sv
// Shared types for the radix-4 Booth multiplier: triplet encoding and FSM states.
package booth_r4_pkg;

   typedef struct packed {
      logic [2:0] encout;
      logic       neg;
   } enc_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   function automatic enc_t booth_r4_enc(input logic [2:0] t);
      enc_t e;
      e.encout[0] = ~(t[2] ^ t[1]);
      e.encout[1] = ~(t[1] ^ t[0]);
      e.encout[2] = t[1] ^ t[0];
      e.neg       = t[2];
      return e;
   endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational partial-product generator: decodes one Booth encoding into 0, +-a or +-2a.
module booth_pp_gen
   import booth_r4_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  enc_t             enc_i,
   output logic [WIDTH+1:0] pp_o
);

   logic             one;
   logic             two;
   logic [WIDTH+1:0] a_ext;
   logic [WIDTH+1:0] mag;

   always_comb begin
      one   = enc_i.encout[2];
      two   = enc_i.encout[1] & ~enc_i.encout[0];
      a_ext = {{2{a_i[WIDTH-1]}}, a_i};
      mag   = '0;
      if (one) begin
         mag = a_ext;
      end else if (two) begin
         mag = a_ext << 1;
      end
      // Two extra bits keep -(2 * -2^(WIDTH-1)) representable.
      pp_o = enc_i.neg ? -mag : mag;
   end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier, one triplet per cycle.
// Define BOOTH_APPROX_TRUNC_EN to zero the low TRUNC_BITS of every aligned partial product.
module booth_r4_seq_mult
   import booth_r4_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned TRUNC_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned N  = WIDTH / 2;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

`ifdef BOOTH_APPROX_TRUNC_EN
   localparam bit APPROX = 1'b1;
`else
   localparam bit APPROX = 1'b0;
`endif

   localparam logic [2*WIDTH-1:0] TRUNC_MASK =
      APPROX ? ({(2*WIDTH){1'b1}} << TRUNC_BITS) : {(2*WIDTH){1'b1}};

   state_t               state_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   acc_d;
   logic [IW-1:0]        idx_q;

   logic [WIDTH:0]       b_ext;
   logic [2:0]           trip;
   enc_t                 enc;
   logic [WIDTH+1:0]     pp;
   logic [2*WIDTH-1:0]   term;

   // b[-1] = 0 is supplied by the appended zero, so triplet i starts at bit 2i.
   always_comb begin
      b_ext = {b_q, 1'b0};
      trip  = b_ext[{idx_q, 1'b0} +: 3];
      enc   = booth_r4_enc(trip);
   end

   booth_pp_gen #(
      .WIDTH (WIDTH)
   ) u_pp_gen (
      .a_i   (a_q),
      .enc_i (enc),
      .pp_o  (pp)
   );

   always_comb begin
      term  = {{(WIDTH-2){pp[WIDTH+1]}}, pp} << {idx_q, 1'b0};
      acc_d = acc_q + (term & TRUNC_MASK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  acc_q      <= '0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_BUSY;
               end
            end
            S_BUSY: begin
               acc_q <= acc_d;
               idx_q <= idx_q + IW'(1);
               if (idx_q == LAST) begin
                  idx_q       <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = acc_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench for booth_r4_seq_mult: WIDTH=8 directed cases plus WIDTH=4 exhaustive sweep.
module tb_booth_r4_seq_mult;

   localparam int TB_TRUNC = 2;
`ifdef BOOTH_APPROX_TRUNC_EN
   localparam bit APPROX = 1'b1;
`else
   localparam bit APPROX = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        iv8, ir8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        iv4, ir4, ov4, or4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] sb8[$];
   logic [7:0]  sb4[$];

   booth_r4_seq_mult #(.WIDTH(8), .TRUNC_BITS(TB_TRUNC)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8), .product(p8));

   booth_r4_seq_mult #(.WIDTH(4), .TRUNC_BITS(TB_TRUNC)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .out_valid(ov4), .out_ready(or4), .product(p4));

   // Exact: plain a*b. Approximate: sum of digit*a*4^i terms, each floored to a multiple of 2^TB_TRUNC.
   function automatic longint model(int w, longint av, longint bv);
      longint acc = 0;
      longint term;
      longint d;
      for (int i = 0; i < w / 2; i++) begin
         d = -2 * ((bv >> (2*i+1)) & 1) + ((bv >> (2*i)) & 1) + ((i == 0) ? 0 : ((bv >> (2*i-1)) & 1));
         term = (av * d) * (longint'(1) << (2*i));
         term = term & ~((longint'(1) << TB_TRUNC) - 1);
         acc += term;
      end
      return APPROX ? acc : av * bv;
   endfunction

   function automatic logic [15:0] exp8(logic [7:0] av, logic [7:0] bv);
      longint r = model(8, longint'($signed(av)), longint'($signed(bv)));
      return r[15:0];
   endfunction

   function automatic logic [7:0] exp4(logic [3:0] av, logic [3:0] bv);
      longint r = model(4, longint'($signed(av)), longint'($signed(bv)));
      return r[7:0];
   endfunction

   task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int hold,
                       output logic [15:0] got, output int lat, output bit hold_ok, output bit ready_after);
      int guard = 0;
      while (!ir8 && guard < 50) begin @(posedge clk); #1; guard++; end
      a8 = av; b8 = bv; iv8 = 1'b1; or8 = 1'b0;
      @(posedge clk); #1;
      iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
      got = p8;
      hold_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (p8 !== got || ir8 !== 1'b0 || ov8 !== 1'b1) hold_ok = 1'b0;
      end
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      ready_after = (ir8 === 1'b1) && (ov8 === 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", ir8); end
      n_cmp++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", ov8); end
      n_cmp++; if (p8 !== 16'd0) begin n_fail++; $display("FAIL reset_product: got %0h expected 0", p8); end
      n_cmp++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin n_fail++; $display("FAIL reset_w4: got ov=%0b ir=%0b expected ov=0 ir=1", ov4, ir4); end
      rst = 1'b0;
   endtask

   task automatic test_directed;
      logic [7:0]  ta[4] = '{8'd3, 8'h80, 8'h80, 8'd7};
      logic [7:0]  tbv[4] = '{8'd5, 8'h80, 8'h7f, 8'hff};
      logic [15:0] got, exp;
      int lat; bit hold_ok, rdy;
      for (int i = 0; i < 4; i++) begin
         sb8.push_back(exp8(ta[i], tbv[i]));
         run8(ta[i], tbv[i], 0, got, lat, hold_ok, rdy);
         exp = sb8.pop_front();
         n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL directed_product[%0d]: got %0d expected %0d", i, $signed(got), $signed(exp)); end
         n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat); end
         n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL directed_ready_after[%0d]: got %0b expected 1", i, rdy); end
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] got, exp;
      int lat; bit hold_ok, rdy;
      sb8.push_back(exp8(8'hfb, 8'd9));
      run8(8'hfb, 8'd9, 10, got, lat, hold_ok, rdy);
      exp = sb8.pop_front();
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL bp_product: got %0d expected %0d", $signed(got), $signed(exp)); end
      n_cmp++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %0b expected 1", hold_ok); end
      n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b expected 1", rdy); end
   endtask

   task automatic test_reset_busy;
      logic [15:0] got, exp;
      int lat; bit hold_ok, rdy, seen_valid;
      a8 = 8'd9; b8 = 8'd9; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if (p8 !== 16'd0) begin n_fail++; $display("FAIL abort_product: got %0h expected 0", p8); end
      n_cmp++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %0b expected 1", ir8); end
      seen_valid = 1'b0;
      or8 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (ov8 !== 1'b0) seen_valid = 1'b1;
         @(posedge clk); #1;
      end
      or8 = 1'b0;
      n_cmp++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got 1 expected 0"); end
      sb8.push_back(exp8(8'd2, 8'd2));
      run8(8'd2, 8'd2, 0, got, lat, hold_ok, rdy);
      exp = sb8.pop_front();
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL abort_next_product: got %0d expected %0d", $signed(got), $signed(exp)); end
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected 4", lat); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] va[5], vb[5];
      int acc_cyc[$];
      int k = 0, outs = 0, cyc = 0;
      bit will_acc, will_out;
      logic [15:0] pcap, exp;
      for (int i = 0; i < 5; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
      or8 = 1'b1;
      while (outs < 5 && cyc < 200) begin
         iv8 = (k < 5); a8 = va[(k < 5) ? k : 0]; b8 = vb[(k < 5) ? k : 0];
         will_acc = iv8 && ir8; will_out = ov8 && or8; pcap = p8;
         @(posedge clk); #1;
         cyc++;
         if (will_acc) begin sb8.push_back(exp8(va[k], vb[k])); acc_cyc.push_back(cyc); k++; end
         if (will_out) begin
            exp = (sb8.size() > 0) ? sb8.pop_front() : 16'hxxxx;
            n_cmp++; if (pcap !== exp) begin n_fail++; $display("FAIL b2b_product[%0d]: got %0h expected %0h", outs, pcap, exp); end
            outs++;
         end
      end
      iv8 = 1'b0; or8 = 1'b0;
      n_cmp++; if (outs !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d expected 5", outs); end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         n_cmp++;
         if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
            n_fail++; $display("FAIL b2b_interval[%0d]: got %0d expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
         end
      end
   endtask

   task automatic test_exhaustive4;
      int k = 0, outs = 0, cyc = 0;
      bit will_acc, will_out;
      logic [7:0] pcap, exp, idx;
      while (outs < 256 && cyc < 20000) begin
         idx = 8'(k);
         a4 = idx[7:4]; b4 = idx[3:0];
         iv4 = (k < 256) && ($urandom_range(0, 3) != 0);
         or4 = ($urandom_range(0, 2) != 0);
         will_acc = iv4 && ir4; will_out = ov4 && or4; pcap = p4;
         @(posedge clk); #1;
         cyc++;
         if (will_acc) begin sb4.push_back(exp4(idx[7:4], idx[3:0])); k++; end
         if (will_out) begin
            exp = (sb4.size() > 0) ? sb4.pop_front() : 8'hxx;
            n_cmp++;
            if (pcap !== exp) begin n_fail++; $display("FAIL w4_product[%0d]: got %0h expected %0h", outs, pcap, exp); end
            outs++;
         end
      end
      iv4 = 1'b0; or4 = 1'b0;
      n_cmp++; if (outs !== 256) begin n_fail++; $display("FAIL w4_count: got %0d expected 256", outs); end
   endtask

   initial begin
      rst = 1'b1;
      iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
      iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
      test_reset;
      test_directed;
      test_backpressure;
      test_reset_busy;
      test_back_to_back;
      test_exhaustive4;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
